// File: rtl/uart_pkg.sv
// uart_pkg: shared UART frame constants and transmit state encoding
// Reused by the receive side. With UART_TX_PARITY_EN defined the PARITY state
// and the even-parity helper exist; otherwise they are absent.
package uart_pkg;
    localparam int   DATA_BITS   = 8;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3
`ifdef UART_TX_PARITY_EN
        , PARITY = 3'd4
`endif
    } tx_state_e;
`ifdef UART_TX_PARITY_EN
    function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
        return ^b;
    endfunction
`endif
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: single-clock transmit byte buffer with registered count
// Ports: clk_i/rst_ni clock and async active-low reset; push_i/wr_data_i write;
// pop_i/rd_data_o read head; count_o occupancy; full_o no room left.
// When empty, rd_data_o shows wr_data_i so a same-cycle push and pop passes
// the byte straight through and the count stays at zero.
module uart_tx_fifo #(
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic [7:0]    wr_data_i,
    input  logic          pop_i,
    output logic [7:0]    rd_data_o,
    output logic [AW:0]   count_o,
    output logic          full_o
);
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    always_comb count_d = count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= wr_data_i;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + AW'(push_i);
            rd_ptr_q <= rd_ptr_q + AW'(pop_i);
            count_q  <= count_d;
        end
    end
    assign rd_data_o = (count_q == '0) ? wr_data_i : mem_q[rd_ptr_q];
    assign count_o   = count_q;
    assign full_o    = count_q == (AW+1)'(DEPTH);
endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: buffered 8N1 UART transmitter (8E1 with UART_TX_PARITY_EN)
// Ports: CLK master clock; rst_n async active-low reset; in_valid/in_byte/in_ready
// byte input handshake; tx serial line (idle high); is_transmitting frame active;
// fifo_level bytes buffered and not yet started.
// tx and is_transmitting are registered from the current state, so the line
// lags the state machine by one cycle and accept-to-start-bit is two cycles.
module uart_tx_buffered #(
    parameter int  SYS_CLK_FREQ = 12000000,
    parameter int  BAUD_RATE    = 9600,
    parameter int  FIFO_DEPTH   = 16,
    localparam int LW           = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          CLK,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [7:0]    in_byte,
    output logic          in_ready,
    output logic          tx,
    output logic          is_transmitting,
    output logic [LW-1:0] fifo_level
);
    import uart_pkg::*;
    localparam int CLKS_PER_BIT = SYS_CLK_FREQ / BAUD_RATE;
    localparam int CW           = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    tx_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d, head;
    logic [1:0]    run_q;
    logic          tx_q, tx_d, busy_q, push, pop, full, bit_done, has_byte;
    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i     (CLK),
        .rst_ni    (rst_n),
        .push_i    (push),
        .wr_data_i (in_byte),
        .pop_i     (pop),
        .rd_data_o (head),
        .count_o   (fifo_level),
        .full_o    (full)
    );
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign bit_done = cnt_q == CW'(CLKS_PER_BIT - 1);
    assign has_byte = fifo_level != '0;
    // Reset release reaches the state machine only after two flops.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) run_q <= '0;
        else        run_q <= {run_q[0], 1'b1};
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = bit_done ? '0 : cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (run_q[1] && has_byte) begin
                    pop     = 1'b1;
                    shift_d = head;
                    state_d = START;
                end
            end
            START: if (bit_done) state_d = DATA;
            DATA: if (bit_done) begin
                idx_d = idx_q + 1'b1;
                if (idx_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_done) state_d = STOP;
`endif
            // A byte pushed in the last stop cycle bypasses an empty FIFO so
            // the next frame follows with no idle gap.
            STOP: if (bit_done) begin
                if (has_byte || push) begin
                    pop     = 1'b1;
                    shift_d = head;
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        tx_d = state_q == START ? START_LEVEL :
               state_q == DATA  ? shift_q[idx_q] :
`ifdef UART_TX_PARITY_EN
               state_q == PARITY ? even_parity(shift_q) :
`endif
               STOP_LEVEL;
    end
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= STOP_LEVEL;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= state_q != IDLE;
        end
    end
    assign tx              = tx_q;
    assign is_transmitting = busy_q;
endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: randomized and directed checks of uart_tx_buffered against a frame-level model
module tb_uart_tx_buffered;
    localparam int SYS   = 120000;
    localparam int BAUD  = 9600;
    localparam int DEPTH = 16;
    localparam int CLKS  = SYS / BAUD;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    logic CLK = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
    logic [7:0] in_byte = '0;
    logic in_ready, tx, is_transmitting;
    logic [$clog2(DEPTH):0] fifo_level;
    int chk_n = 0, err_n = 0, cyc = 0, done_n = 0, idle_bad = 0;
    int t0 = 0, bad = 0, off = 0;
    logic mon_busy = 1'b0;
    logic [FB-1:0] exp_frame = '1;
    logic [7:0] exp_q[$];
    int starts[$];

    uart_tx_buffered #(.SYS_CLK_FREQ(SYS), .BAUD_RATE(BAUD), .FIFO_DEPTH(DEPTH)) dut (
        .CLK             (CLK),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_byte         (in_byte),
        .in_ready        (in_ready),
        .tx              (tx),
        .is_transmitting (is_transmitting),
        .fifo_level      (fifo_level)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_n++;
        if (got !== exp) begin
            err_n++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected line levels of one frame, index 0 = start bit, data LSB first.
    function automatic logic [FB-1:0] frame_of(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return {1'b1, (ones % 2) == 1, b, 1'b0};
`else
        return {1'b1, b, 1'b0};
`endif
    endfunction

    // Line monitor: every cycle of a frame must match the expected byte's frame.
    always @(negedge CLK) begin
        if (!rst_n) begin
            mon_busy = 1'b0;
        end else if (!mon_busy) begin
            if (tx === 1'b0) begin
                mon_busy = 1'b1;
                t0 = cyc;
                bad = 0;
                starts.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 1, 0);
                    exp_frame = '1;
                end else begin
                    exp_frame = frame_of(exp_q.pop_front());
                end
                if (is_transmitting !== 1'b1) bad++;
            end else if (is_transmitting !== 1'b0) begin
                idle_bad++;
            end
        end else begin
            off = cyc - t0;
            if (tx !== exp_frame[off / CLKS] || is_transmitting !== 1'b1) bad++;
            if (off == FB * CLKS - 1) begin
                check("frame_wave", bad, 0);
                done_n++;
                mon_busy = 1'b0;
            end
        end
    end

    task automatic push(input logic [7:0] b);
        @(negedge CLK);
        in_valid = 1'b1;
        in_byte  = b;
    endtask

    task automatic release_in();
        @(negedge CLK);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int n);
        int budget = (n - done_n + 2) * FB * CLKS + 50;
        for (int k = 0; k < budget && done_n < n; k++) begin
            @(negedge CLK);
            #1;
        end
        check("frames_done", done_n, n);
    endtask

    task automatic wait_start(input int n);
        for (int k = 0; k < 4 * FB * CLKS && starts.size() < n; k++) begin
            @(negedge CLK);
            #1;
        end
        check("frame_started", starts.size() >= n, 1);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge CLK);
    endtask

    initial begin
        int acc, n0, s0, mx, n;
        logic [7:0] b;
        repeat (3) @(negedge CLK);
        #1;
        check("rst_tx", tx, 1);
        check("rst_busy", is_transmitting, 0);
        check("rst_level", fifo_level, 0);
        check("rst_ready", in_ready, 1);
        @(negedge CLK);
        rst_n = 1'b1;
        repeat (4) @(negedge CLK);

        // Single 0x55 frame: level, accept-to-start latency, waveform
        exp_q.push_back(8'h55);
        push(8'h55);
        release_in();
        acc = cyc;
        #1;
        check("level_after_accept", fifo_level, 1);
        wait_start(1);
        check("start_latency", starts[0] - acc, 2);
        wait_done(1);

        // Three consecutive pushes: back-to-back frames, level trace
        n0 = done_n;
        s0 = starts.size();
        foreach (exp_q[i]) check("exp_q_empty", 1, 0);
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h42);
        exp_q.push_back(8'h43);
        push(8'h41);
        push(8'h42);
        push(8'h43);
        release_in();
        #1;
        check("level_three_pushed", fifo_level, 2);
        wait_done(n0 + 1);
        check("level_after_first", fifo_level, 1);
        wait_done(n0 + 2);
        check("level_after_second", fifo_level, 0);
        wait_done(n0 + 3);
        check("gap_41_42", starts[s0 + 1] - starts[s0], FB * CLKS);
        check("gap_42_43", starts[s0 + 2] - starts[s0 + 1], FB * CLKS);

        // Parity-sensitive patterns (odd and even number of ones)
        n0 = done_n;
        exp_q.push_back(8'h07);
        exp_q.push_back(8'h03);
        push(8'h07);
        push(8'h03);
        release_in();
        wait_done(n0 + 2);

        // Random bursts, never near full so every byte must be accepted
        for (int r = 0; r < 6; r++) begin
            n0 = done_n;
            n = $urandom_range(1, 6);
            for (int j = 0; j < n; j++) begin
                repeat ($urandom_range(0, 30)) @(negedge CLK);
                b = 8'($urandom);
                push(b);
                check("rand_ready", in_ready, 1);
                exp_q.push_back(b);
                release_in();
            end
            wait_done(n0 + n);
        end

        // Overflow: one in flight plus 16 buffered, the 18th byte is dropped
        n0 = done_n;
        for (int j = 0; j < 17; j++) begin
            b = 8'($urandom);
            push(b);
            exp_q.push_back(b);
        end
        release_in();
        #1;
        check("full_ready", in_ready, 0);
        check("full_level", fifo_level, DEPTH);
        push(8'hEE);
        release_in();
        wait_done(n0 + 17);
        repeat (2 * FB * CLKS) @(negedge CLK);
        #1;
        check("overflow_frames", done_n, n0 + 17);

        // Push during the final stop cycle with an empty FIFO
        n0 = done_n;
        s0 = starts.size();
        exp_q.push_back(8'hA5);
        push(8'hA5);
        release_in();
        wait_start(s0 + 1);
        wait_cyc(starts[s0] + FB * CLKS - 2);
        check("stop_fifo_empty", fifo_level, 0);
        in_valid = 1'b1;
        in_byte  = 8'h3C;
        exp_q.push_back(8'h3C);
        mx = 0;
        @(negedge CLK);
        in_valid = 1'b0;
        for (int k = 0; k < FB * CLKS; k++) begin
            #1;
            if (int'(fifo_level) > mx) mx = int'(fifo_level);
            @(negedge CLK);
        end
        check("stop_push_level_le1", mx <= 1, 1);
        wait_done(n0 + 2);
        check("stop_push_gap", starts[s0 + 1] - starts[s0], FB * CLKS);

        // Reset in the middle of data bit 3 of 0x00 with bytes still buffered
        s0 = starts.size();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        push(8'h00);
        push(8'h11);
        push(8'h22);
        release_in();
        wait_start(s0 + 1);
        wait_cyc(starts[s0] + 4 * CLKS + CLKS / 2);
        #1;
        check("bit3_low", tx, 0);
        rst_n = 1'b0;
        #1;
        check("abort_tx", tx, 1);
        check("abort_level", fifo_level, 0);
        check("abort_busy", is_transmitting, 0);
        exp_q.delete();
        repeat (3) @(negedge CLK);
        rst_n = 1'b1;
        s0 = starts.size();
        repeat (3 * FB * CLKS) @(negedge CLK);
        #1;
        check("no_frames_after_reset", starts.size(), s0);
        check("tx_idle_after_reset", tx, 1);

        check("idle_busy_low", idle_bad, 0);
        check("leftover_expected", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", err_n, chk_n);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
        $fatal(1);
    end
endmodule
